// File: rtl/inst_seq_ctrl.sv
// Instruction buffer and in-order sequencer: the host loads a program, which is then
// issued to every core over valid/ready, optionally replayed, with a mem_in snapshot per issue.
module inst_seq_ctrl #(
  parameter int INST_W   = 17,
  parameter int DEPTH    = 16,
  parameter int NUM_CORE = 2,
  parameter int bw       = 8,
  parameter int pr       = 16,
  parameter int RPT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_wr,
  input  logic [INST_W-1:0]   inst_in,
  output logic                inst_mem_full,
  output logic                wr_ovf,
  input  logic                start_ex,
  input  logic [RPT_W-1:0]    rpt,
  input  logic                clr,
  output logic [INST_W-1:0]   inst_out,
  output logic                inst_valid,
  input  logic [NUM_CORE-1:0] inst_ready,
  input  logic [pr*bw-1:0]    mem_in,
  output logic [pr*bw-1:0]    mem_out,
  output logic                busy,
  output logic                done,
  output logic [RPT_W-1:0]    pass_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int MW = pr * bw;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [AW:0]       count_q, count_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [RPT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [RPT_W-1:0]  rpt_q, rpt_d;
  logic [INST_W-1:0] inst_out_q, inst_out_d;
  logic [MW-1:0]     mem_out_q, mem_out_d;
  logic              inst_valid_q, inst_valid_d;
  logic              full_q, full_d;
  logic              wr_ovf_q, wr_ovf_d;

  logic [INST_W-1:0] mem [DEPTH];

  logic              hs, wr_en, last_entry, start_go, advance, wrap, fwd0;
  logic [AW:0]       count_wr, next_idx;
  logic [AW-1:0]     rd_addr;
  logic [INST_W-1:0] rd_data;

  assign hs         = inst_valid_q & (&inst_ready);
  assign wr_en      = (state_q == S_LOAD) && inst_wr && !clr && (count_q != FULL_CNT);
  assign count_wr   = wr_en ? count_q + (AW+1)'(1) : count_q;
  assign next_idx   = {1'b0, rd_ptr_q} + (AW+1)'(1);
  assign last_entry = (next_idx >= count_q);
  assign advance    = (state_q == S_RUN) && !clr && hs && (!last_entry || (pass_cnt_q != rpt_q));
  assign wrap       = advance && last_entry;
  assign start_go   = (state_d == S_RUN) && (state_q != S_RUN);
  // A start in the same cycle as the very first write must see that write, not stale memory.
  assign fwd0       = wr_en && (count_q == '0);
  assign rd_addr    = (advance && !wrap) ? next_idx[AW-1:0] : '0;
  assign rd_data    = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: if (!clr && start_ex && (count_wr != '0)) state_d = S_RUN;
      S_RUN: begin
        if (clr)                                             state_d = S_LOAD;
        else if (hs && last_entry && (pass_cnt_q == rpt_q))  state_d = S_DONE;
      end
      S_DONE: begin
        if (clr)           state_d = S_LOAD;
        else if (start_ex) state_d = S_RUN;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    count_d      = count_wr;
    full_d       = full_q;
    wr_ovf_d     = wr_ovf_q;
    rd_ptr_d     = rd_ptr_q;
    pass_cnt_d   = pass_cnt_q;
    rpt_d        = rpt_q;
    inst_out_d   = inst_out_q;
    mem_out_d    = mem_out_q;
    inst_valid_d = inst_valid_q;

    if (wr_en)            full_d   = (count_wr == FULL_CNT);
    if (inst_wr && !wr_en) wr_ovf_d = 1'b1;

    if (start_go) begin
      rpt_d        = rpt;
      rd_ptr_d     = '0;
      pass_cnt_d   = '0;
      inst_valid_d = 1'b1;
      inst_out_d   = fwd0 ? inst_in : rd_data;
      mem_out_d    = mem_in;
    end else if (advance) begin
      rd_ptr_d   = wrap ? '0 : next_idx[AW-1:0];
      if (wrap) pass_cnt_d = pass_cnt_q + RPT_W'(1);
      inst_out_d = rd_data;
      mem_out_d  = mem_in;
    end else if ((state_q == S_RUN) && hs) begin
      inst_valid_d = 1'b0;
    end

    if (clr) begin
      count_d      = '0;
      full_d       = 1'b0;
      inst_valid_d = 1'b0;
      if (state_q != S_RUN) begin
        pass_cnt_d = '0;
        wr_ovf_d   = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      full_q       <= 1'b0;
      wr_ovf_q     <= 1'b0;
      rd_ptr_q     <= '0;
      pass_cnt_q   <= '0;
      rpt_q        <= '0;
      inst_out_q   <= '0;
      mem_out_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      full_q       <= full_d;
      wr_ovf_q     <= wr_ovf_d;
      rd_ptr_q     <= rd_ptr_d;
      pass_cnt_q   <= pass_cnt_d;
      rpt_q        <= rpt_d;
      inst_out_q   <= inst_out_d;
      mem_out_q    <= mem_out_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // NOTE: the array has no reset; count_q==0 already makes every entry unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count_q[AW-1:0]] <= inst_in;
  end

  assign inst_mem_full = full_q;
  assign wr_ovf        = wr_ovf_q;
  assign inst_out      = inst_out_q;
  assign inst_valid    = inst_valid_q;
  assign mem_out       = mem_out_q;
  assign pass_cnt      = pass_cnt_q;

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Randomized bench for inst_seq_ctrl: a queue holds the loaded program and the expected
// issue stream is derived as program repeated (rpt+1) times.
module tb_inst_seq_ctrl;
  localparam int INST_W   = 17;
  localparam int DEPTH    = 16;
  localparam int NUM_CORE = 2;
  localparam int BW       = 8;
  localparam int PR       = 16;
  localparam int RPT_W    = 8;
  localparam int MW       = PR * BW;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                inst_wr = 1'b0;
  logic [INST_W-1:0]   inst_in = '0;
  logic                inst_mem_full, wr_ovf;
  logic                start_ex = 1'b0;
  logic [RPT_W-1:0]    rpt = '0;
  logic                clr = 1'b0;
  logic [INST_W-1:0]   inst_out;
  logic                inst_valid;
  logic [NUM_CORE-1:0] inst_ready = '0;
  logic [MW-1:0]       mem_in = '0;
  logic [MW-1:0]       mem_out;
  logic                busy, done;
  logic [RPT_W-1:0]    pass_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [INST_W-1:0] prog[$];
  bit                exp_ovf = 1'b0;

  inst_seq_ctrl #(
    .INST_W(INST_W), .DEPTH(DEPTH), .NUM_CORE(NUM_CORE), .bw(BW), .pr(PR), .RPT_W(RPT_W)
  ) dut (
    .clk(clk), .reset(reset), .inst_wr(inst_wr), .inst_in(inst_in),
    .inst_mem_full(inst_mem_full), .wr_ovf(wr_ovf), .start_ex(start_ex), .rpt(rpt),
    .clr(clr), .inst_out(inst_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .mem_in(mem_in), .mem_out(mem_out), .busy(busy), .done(done), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_words(input int n, input bit seq);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("full_load", inst_mem_full, prog.size() == DEPTH);
        check("ovf_load", wr_ovf, exp_ovf);
      end
      inst_wr = 1'b1;
      inst_in = seq ? INST_W'(i + 1) : INST_W'($urandom);
      if (prog.size() < DEPTH) prog.push_back(inst_in);
      else                     exp_ovf = 1'b1;
    end
    @(negedge clk);
    inst_wr = 1'b0;
    check("full_load", inst_mem_full, prog.size() == DEPTH);
    check("ovf_load", wr_ovf, exp_ovf);
  endtask

  // mode 0: all cores ready; 1: one of 01/10/11; 2: fully random ready
  task automatic run_prog(input int r, input int mode, input bit wr_with_start);
    int n, total, issued, cyc;
    logic [MW-1:0] exp_mem;
    @(negedge clk);
    start_ex   = 1'b1;
    rpt        = RPT_W'(r);
    mem_in     = rand_word();
    exp_mem    = mem_in;
    inst_ready = '0;
    if (wr_with_start) begin
      inst_wr = 1'b1;
      inst_in = INST_W'($urandom);
      prog.push_back(inst_in);
    end
    n      = prog.size();
    total  = n * (r + 1);
    issued = 0;
    cyc    = 0;
    @(negedge clk);
    start_ex = 1'b0;
    inst_wr  = 1'b0;
    check("valid_latency", inst_valid, 1'b1);
    while (issued < total && cyc < total * 20 + 50) begin
      check("valid_run", inst_valid, 1'b1);
      check("busy_run", busy, 1'b1);
      check("inst_out", inst_out, prog[issued % n]);
      check("mem_out", mem_out, exp_mem);
      check("pass_cnt", pass_cnt, RPT_W'(issued / n));
      case (mode)
        0:       inst_ready = 2'b11;
        1:       inst_ready = 2'($urandom_range(1, 3));
        default: inst_ready = 2'($urandom_range(0, 3));
      endcase
      mem_in = rand_word();
      if (&inst_ready) begin
        issued++;
        if (issued < total) exp_mem = mem_in;
      end
      @(negedge clk);
      cyc++;
    end
    inst_ready = '0;
    check("issue_count", issued, total);
    check("valid_done", inst_valid, 1'b0);
    check("done_flag", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("pass_final", pass_cnt, RPT_W'(r));
  endtask

  task automatic clear_prog(input bit with_start);
    @(negedge clk);
    clr      = 1'b1;
    start_ex = with_start;
    @(negedge clk);
    clr      = 1'b0;
    start_ex = 1'b0;
    prog.delete();
    exp_ovf = 1'b0;
    check("clr_busy", busy, 1'b0);
    check("clr_done", done, 1'b0);
    check("clr_valid", inst_valid, 1'b0);
    check("clr_full", inst_mem_full, 1'b0);
    check("clr_ovf", wr_ovf, 1'b0);
    // an empty program must not start
    start_ex = 1'b1;
    @(negedge clk);
    start_ex = 1'b0;
    check("empty_start_busy", busy, 1'b0);
    check("empty_start_valid", inst_valid, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_valid", inst_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_full", inst_mem_full, 1'b0);
    check("rst_ovf", wr_ovf, 1'b0);
    check("rst_pass", pass_cnt, '0);
    check("rst_inst", inst_out, '0);

    // single pass of 1..5 with all cores ready
    load_words(5, 1'b1);
    run_prog(0, 0, 1'b0);

    // a write in DONE is dropped and flagged
    @(negedge clk);
    inst_wr = 1'b1;
    inst_in = INST_W'(17'h1abcd);
    @(negedge clk);
    inst_wr = 1'b0;
    exp_ovf = 1'b1;
    check("ovf_in_done", wr_ovf, 1'b1);

    // re-run from DONE without reloading, with partial-ready stalls
    run_prog(1, 1, 1'b0);
    clear_prog(1'b1);

    // fill to capacity plus one overflowing write
    load_words(DEPTH + 1, 1'b0);
    run_prog(0, 2, 1'b0);
    clear_prog(1'b0);

    // three entries replayed three times
    load_words(3, 1'b1);
    run_prog(2, 1, 1'b0);
    clear_prog(1'b0);

    for (int ep = 0; ep < 6; ep++) begin
      load_words($urandom_range(1, DEPTH), 1'b0);
      run_prog($urandom_range(0, 3), 2, 1'b0);
      clear_prog(1'b0);
    end

    // reset while the third instruction is on the bus
    load_words(4, 1'b1);
    @(negedge clk);
    start_ex   = 1'b1;
    rpt        = '0;
    inst_ready = 2'b11;
    @(negedge clk);
    start_ex = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_inst", inst_out, INST_W'(3));
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    inst_ready = '0;
    prog.delete();
    exp_ovf = 1'b0;
    check("mid_rst_valid", inst_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_full", inst_mem_full, 1'b0);
    check("mid_rst_pass", pass_cnt, '0);
    start_ex = 1'b1;
    @(negedge clk);
    start_ex = 1'b0;
    check("post_rst_start_busy", busy, 1'b0);
    check("post_rst_start_valid", inst_valid, 1'b0);

    // first write and start in the same cycle: the new entry is issued
    run_prog(1, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
